mitchell_seq_ctrl: RTL

Sequencing controller for the low-power Mitchell error-tolerant multiplier (ETM). It accepts one 8x8 unsigned operand pair per transaction over a valid/ready handshake, time-multiplexes a single external shared `lod_enc` (thermometer-to-position encoder) across both operands, and forms the Mitchell log-add-antilog product. Operand pairs whose upper nibbles are both zero bypass the approximation and are multiplied exactly. The block sits between the operand source and the product sink, and owns the `lod_enc` input bus.

---
 rtl/mitchell_pkg.sv | 34 +++
 rtl/mitchell_antilog.sv | 41 ++++
 rtl/mitchell_seq_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mitchell_pkg.sv
// Shared definitions for the Mitchell ETM sequencing controller.
//   - state_t : controller FSM states
//   - path_t  : exact vs. Mitchell-approximate product path
//   - smear() : thermometer code fed to the shared leading-one encoder
package mitchell_pkg;

    localparam int W  = 8;   // operand width
    localparam int FW = 7;   // fraction width (Q7)
    localparam int KW = 3;   // leading-one position width

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC_A,
        S_ENC_B,
        S_CALC,
        S_OUT
    } state_t;

    typedef enum logic {
        PATH_EXACT,
        PATH_MITCH
    } path_t;

    // smear(x)[i] = |x[W-1:i]: every bit at and below the leading one is set.
    function automatic logic [W-1:0] smear(input logic [W-1:0] x);
        logic [W-1:0] r;
        r[W-1] = x[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            r[i] = r[i+1] | x[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mitchell_antilog.sv
// Mitchell log-add-antilog datapath (purely combinational).
// Ports:
//   k_a, k_b : leading-one positions of the two operands
//   a_r, b_r : registered operands (both non-zero when this result is used)
//   p        : 16-bit approximate product, floor-truncated
module mitchell_antilog
    import mitchell_pkg::*;
(
    input  logic [KW-1:0]  k_a,
    input  logic [KW-1:0]  k_b,
    input  logic [W-1:0]   a_r,
    input  logic [W-1:0]   b_r,
    output logic [2*W-1:0] p
);

    logic [FW-1:0] f_a, f_b;
    logic [FW:0]   s;
    logic [KW:0]   k;
    logic [23:0]   m;

    // Normalise so the leading one lands at bit FW; the bits below it are
    // the Q7 fraction and the leading one itself is dropped by the cast.
    assign f_a = FW'({8'd0, a_r} << (KW'(FW) - k_a));
    assign f_b = FW'({8'd0, b_r} << (KW'(FW) - k_b));

    assign s = {1'b0, f_a} + {1'b0, f_b};
    assign k = {1'b0, k_a} + {1'b0, k_b};

    // No carry: 2^k * (1 + s).  Carry: 2^(k+1) * s, where s already holds
    // the carried-in integer one.
    always_comb begin
        if (!s[FW]) begin
            m = {16'd0, 1'b1, s[FW-1:0]} << k;
        end else begin
            m = {16'd0, s} << (k + 4'd1);
        end
    end

    assign p = 16'(m >> FW);

endmodule

// File: rtl/mitchell_seq_ctrl.sv
// Sequencing controller for the Mitchell error-tolerant multiplier.
// Accepts one operand pair per transaction, time-shares the external
// combinational lod_enc across both operands, and returns either the
// Mitchell approximate product or, for small/zero operands, the exact one.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   a, b                 : operands, sampled on accept
//   lod_a / lod_c        : thermometer code out / leading-one position back
//   out_valid/out_ready  : product handshake
//   p                    : product, held while out_valid
module mitchell_seq_ctrl #(
    parameter int W     = 8,
    parameter int SPLIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   lod_a,
    input  logic [2:0]     lod_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    import mitchell_pkg::*;

    state_t         state_q, state_d;
    path_t          path_q, path_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]     ka_q, ka_d, kb_q, kb_d;
    logic [2*W-1:0] p_q, p_d;
    logic [2*W-1:0] p_mitch;
    logic           take_exact;

    mitchell_antilog u_antilog (
        .k_a (ka_q),
        .k_b (kb_q),
        .a_r (a_q),
        .b_r (b_q),
        .p   (p_mitch)
    );

    // Zero operands have no leading one, so they must bypass the encoder.
    assign take_exact = (a == '0) || (b == '0) ||
                        ((a[W-1:SPLIT] == '0) && (b[W-1:SPLIT] == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            path_q  <= PATH_EXACT;
            a_q     <= '0;
            b_q     <= '0;
            ka_q    <= '0;
            kb_q    <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        path_d    = path_q;
        a_d       = a_q;
        b_d       = b_q;
        ka_d      = ka_q;
        kb_d      = kb_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lod_a     = '0;   // keeps the shared encoder quiet when unused
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    if (take_exact) begin
                        path_d  = PATH_EXACT;
                        state_d = S_CALC;
                    end else begin
                        path_d  = PATH_MITCH;
                        state_d = S_ENC_A;
                    end
                end
            end
            S_ENC_A: begin
                lod_a   = smear(a_q);
                ka_d    = lod_c;
                state_d = S_ENC_B;
            end
            S_ENC_B: begin
                lod_a   = smear(b_q);
                kb_d    = lod_c;
                state_d = S_CALC;
            end
            S_CALC: begin
                p_d     = (path_q == PATH_EXACT) ? ({8'd0, a_q} * {8'd0, b_q}) : p_mitch;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign p = p_q;

endmodule
